// File: rtl/timer_countdown_alarm.sv
// Kitchen-timer execution unit: loads a duration, counts it down once per second,
// flags zero, sounds the buzzer for ALARM_SEC seconds and reports completion.
// Every output comes straight from a flop; digit outputs trail remaining by one cycle.
module timer_countdown_alarm #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int ALARM_SEC = 10,
    parameter int BEEP_DIV  = 25_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] mode_count,
    input  logic       start_count,
    input  logic       start_alarm,
    input  logic       stop,
    output logic       flag_sec_equal_zero,
    output logic       end_alarm,
    output logic [7:0] remaining,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       buzzer,
    output logic       tick_1hz
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam int BW = $clog2(BEEP_DIV + 1);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOADED, RUN, ALARM} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] prescaler, prescaler_nx;
    logic [AW-1:0] alarm_cnt, alarm_cnt_nx;
    logic [BW-1:0] beep_cnt, beep_cnt_nx;
    logic [7:0]    remaining_nx;
    logic          flag_nx, end_nx, buzzer_nx, tick_nx;
    // alarm_armed records that start_alarm has been seen low, so a held-high
    // request cannot restart the alarm after completion, abort or reset.
    logic          alarm_armed, armed_nx;
    logic          alarm_req, abort;

    // State and all registered outputs; reset returns everything to zero at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            prescaler           <= '0;
            alarm_cnt           <= '0;
            beep_cnt            <= '0;
            remaining           <= 8'd0;
            flag_sec_equal_zero <= 1'b0;
            end_alarm           <= 1'b0;
            buzzer              <= 1'b0;
            tick_1hz            <= 1'b0;
            alarm_armed         <= 1'b0;
        end else begin
            state               <= state_nx;
            prescaler           <= prescaler_nx;
            alarm_cnt           <= alarm_cnt_nx;
            beep_cnt            <= beep_cnt_nx;
            remaining           <= remaining_nx;
            flag_sec_equal_zero <= flag_nx;
            end_alarm           <= end_nx;
            buzzer              <= buzzer_nx;
            tick_1hz            <= tick_nx;
            alarm_armed         <= armed_nx;
        end
    end

    // Next-state logic in priority order stop > start_alarm > start_count > load.
    always_comb begin
        state_nx     = state;
        prescaler_nx = prescaler;
        alarm_cnt_nx = alarm_cnt;
        beep_cnt_nx  = beep_cnt;
        remaining_nx = remaining;
        flag_nx      = flag_sec_equal_zero;
        end_nx       = 1'b0;
        buzzer_nx    = buzzer;
        tick_nx      = 1'b0;
        armed_nx     = alarm_armed | ~start_alarm;
        alarm_req    = start_alarm & alarm_armed;
        abort        = 1'b0;

        if (stop) begin
            abort = 1'b1;
        end else if (state == ALARM) begin
            if (!start_alarm) begin
                abort = 1'b1;
            end else begin
                if (beep_cnt == BEEP_LAST) begin
                    beep_cnt_nx = '0;
                    buzzer_nx   = ~buzzer;
                end else begin
                    beep_cnt_nx = beep_cnt + 1'b1;
                end
                if (prescaler == TICK_LAST) begin
                    prescaler_nx = '0;
                    tick_nx      = 1'b1;
                    alarm_cnt_nx = alarm_cnt + 1'b1;
                    if (alarm_cnt == ALARM_LAST) begin
                        end_nx       = 1'b1;
                        state_nx     = IDLE;
                        buzzer_nx    = 1'b0;
                        remaining_nx = 8'd0;
                        alarm_cnt_nx = '0;
                        beep_cnt_nx  = '0;
                    end
                end else begin
                    prescaler_nx = prescaler + 1'b1;
                end
            end
        end else if (alarm_req) begin
            state_nx     = ALARM;
            prescaler_nx = '0;
            alarm_cnt_nx = '0;
            beep_cnt_nx  = '0;
            buzzer_nx    = 1'b0;
            flag_nx      = 1'b0;
            armed_nx     = 1'b0;
        end else if (state == RUN) begin
            if (start_count && remaining != 8'd0) begin
                if (prescaler == TICK_LAST) begin
                    prescaler_nx = '0;
                    tick_nx      = 1'b1;
                    remaining_nx = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        flag_nx = 1'b1;
                    end
                end else begin
                    prescaler_nx = prescaler + 1'b1;
                end
            end
        end else if (state == LOADED && start_count) begin
            state_nx     = RUN;
            prescaler_nx = '0;
            if (remaining == 8'd0) begin
                flag_nx = 1'b1;
            end
        end else if (load) begin
            state_nx     = LOADED;
            remaining_nx = mode_count;
            prescaler_nx = '0;
        end

        if (abort) begin
            state_nx     = IDLE;
            remaining_nx = 8'd0;
            prescaler_nx = '0;
            alarm_cnt_nx = '0;
            beep_cnt_nx  = '0;
            buzzer_nx    = 1'b0;
            flag_nx      = 1'b0;
            end_nx       = 1'b0;
            tick_nx      = 1'b0;
        end
    end

    // M:SS display digits derived from the registered remaining count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_digit <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
        end else begin
            min_digit <= 4'(remaining / 8'd60);
            sec_tens  <= 4'((remaining % 8'd60) / 8'd10);
            sec_ones  <= 4'((remaining % 8'd60) % 8'd10);
        end
    end

endmodule

// File: tb/tb_timer_countdown_alarm.sv
// Directed bench for timer_countdown_alarm with TICK_DIV=4, ALARM_SEC=3, BEEP_DIV=2.
module tb_timer_countdown_alarm;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [7:0] mode_count;
    logic       start_count;
    logic       start_alarm;
    logic       stop;
    logic       flag_sec_equal_zero;
    logic       end_alarm;
    logic [7:0] remaining;
    logic [3:0] min_digit;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       buzzer;
    logic       tick_1hz;

    int n_compared = 0;
    int n_failed   = 0;

    logic [26:0] all_out;
    assign all_out = {flag_sec_equal_zero, end_alarm, remaining, min_digit,
                      sec_tens, sec_ones, buzzer, tick_1hz};

    timer_countdown_alarm #(.TICK_DIV(4), .ALARM_SEC(3), .BEEP_DIV(2)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .load                (load),
        .mode_count          (mode_count),
        .start_count         (start_count),
        .start_alarm         (start_alarm),
        .stop                (stop),
        .flag_sec_equal_zero (flag_sec_equal_zero),
        .end_alarm           (end_alarm),
        .remaining           (remaining),
        .min_digit           (min_digit),
        .sec_tens            (sec_tens),
        .sec_ones            (sec_ones),
        .buzzer              (buzzer),
        .tick_1hz            (tick_1hz)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; load = 1'b0; mode_count = 8'd0;
        start_count = 1'b0; start_alarm = 1'b0; stop = 1'b0;
        #3;
        n_compared++;
        if (all_out !== 27'd0) begin
            n_failed++; $display("[TB] FAIL reset_outputs: actual=%0h required=0", all_out);
        end
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        n_compared++;
        if (all_out !== 27'd0) begin
            n_failed++; $display("[TB] FAIL idle_after_reset: actual=%0h required=0", all_out);
        end
    endtask

    task automatic test_count3;
        load = 1'b1; mode_count = 8'd3;
        cyc(1);
        n_compared++;
        if ({remaining, flag_sec_equal_zero} !== {8'd3, 1'b0}) begin
            n_failed++; $display("[TB] FAIL load3: actual rem=%0d flag=%0d required rem=3 flag=0", remaining, flag_sec_equal_zero);
        end
        load = 1'b0; start_count = 1'b1;
        cyc(1);
        n_compared++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h003) begin
            n_failed++; $display("[TB] FAIL digits3: actual=%0h required=003", {min_digit, sec_tens, sec_ones});
        end
        for (int i = 1; i <= 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(1);
                n_compared++;
                if (tick_1hz !== 1'b0) begin
                    n_failed++; $display("[TB] FAIL count3_notick: actual=%0d required=0", tick_1hz);
                end
            end
            cyc(1);
            n_compared++;
            if ({tick_1hz, remaining, flag_sec_equal_zero} !== {1'b1, 8'(3 - i), (i == 3)}) begin
                n_failed++; $display("[TB] FAIL count3_tick: actual tick=%0d rem=%0d flag=%0d required tick=1 rem=%0d flag=%0d",
                                     tick_1hz, remaining, flag_sec_equal_zero, 3 - i, (i == 3));
            end
        end
        cyc(1);
        n_compared++;
        if ({min_digit, sec_tens, sec_ones, tick_1hz} !== 13'h0) begin
            n_failed++; $display("[TB] FAIL digits0: actual=%0h required=0", {min_digit, sec_tens, sec_ones, tick_1hz});
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            n_compared++;
            if ({tick_1hz, remaining, flag_sec_equal_zero} !== {1'b0, 8'd0, 1'b1}) begin
                n_failed++; $display("[TB] FAIL zero_hold: actual tick=%0d rem=%0d flag=%0d required 0/0/1", tick_1hz, remaining, flag_sec_equal_zero);
            end
        end
    endtask

    task automatic test_alarm;
        start_count = 1'b0; start_alarm = 1'b1;
        cyc(1);
        n_compared++;
        if ({buzzer, flag_sec_equal_zero, end_alarm} !== 3'b000) begin
            n_failed++; $display("[TB] FAIL alarm_entry: actual=%0b required=000", {buzzer, flag_sec_equal_zero, end_alarm});
        end
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            n_compared++;
            if ({buzzer, end_alarm, tick_1hz} !== {((c / 2) % 2 == 1) && c < 12, c == 12, c % 4 == 0}) begin
                n_failed++; $display("[TB] FAIL alarm_cycle%0d: actual buz/end/tick=%0b required=%0b", c,
                                     {buzzer, end_alarm, tick_1hz}, {((c / 2) % 2 == 1) && c < 12, c == 12, c % 4 == 0});
            end
        end
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            n_compared++;
            if ({buzzer, end_alarm, remaining} !== 10'd0) begin
                n_failed++; $display("[TB] FAIL alarm_no_reentry: actual buz=%0d end=%0d rem=%0d required 0", buzzer, end_alarm, remaining);
            end
        end
        start_alarm = 1'b0;
        cyc(1);
    endtask

    task automatic test_pause120;
        int  ticks;
        bit  done;
        load = 1'b1; mode_count = 8'd120;
        cyc(1);
        load = 1'b0; start_count = 1'b1;
        cyc(1);
        n_compared++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h200) begin
            n_failed++; $display("[TB] FAIL digits120: actual=%0h required=200", {min_digit, sec_tens, sec_ones});
        end
        cyc(4);
        n_compared++;
        if ({tick_1hz, remaining} !== {1'b1, 8'd119}) begin
            n_failed++; $display("[TB] FAIL first_tick120: actual tick=%0d rem=%0d required 1/119", tick_1hz, remaining);
        end
        ticks = 1;
        cyc(1);
        n_compared++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h159) begin
            n_failed++; $display("[TB] FAIL digits119: actual=%0h required=159", {min_digit, sec_tens, sec_ones});
        end
        start_count = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            n_compared++;
            if ({tick_1hz, remaining} !== {1'b0, 8'd119}) begin
                n_failed++; $display("[TB] FAIL pause_hold: actual tick=%0d rem=%0d required 0/119", tick_1hz, remaining);
            end
        end
        start_count = 1'b1;
        cyc(2);
        n_compared++;
        if (tick_1hz !== 1'b0) begin
            n_failed++; $display("[TB] FAIL resume_early: actual tick=%0d required 0", tick_1hz);
        end
        cyc(1);
        n_compared++;
        if ({tick_1hz, remaining} !== {1'b1, 8'd118}) begin
            n_failed++; $display("[TB] FAIL resume_tick: actual tick=%0d rem=%0d required 1/118", tick_1hz, remaining);
        end
        ticks = 2;
        done  = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            cyc(1);
            if (tick_1hz) ticks++;
            if (flag_sec_equal_zero) done = 1'b1;
        end
        n_compared++;
        if (!done) begin
            n_failed++; $display("[TB] FAIL count120_timeout: actual flag=0 required flag=1 within 600 cycles");
        end
        n_compared++;
        if ({ticks, remaining} !== {32'd120, 8'd0}) begin
            n_failed++; $display("[TB] FAIL count120_total: actual ticks=%0d rem=%0d required 120/0", ticks, remaining);
        end
        stop = 1'b1; cyc(1); stop = 1'b0; start_count = 1'b0;
        cyc(1);
    endtask

    task automatic test_stop;
        load = 1'b1; mode_count = 8'd3;
        cyc(1);
        load = 1'b0; start_count = 1'b1;
        cyc(5);
        n_compared++;
        if (remaining !== 8'd2) begin
            n_failed++; $display("[TB] FAIL stop_setup: actual rem=%0d required 2", remaining);
        end
        stop = 1'b1;
        cyc(1);
        n_compared++;
        if ({remaining, flag_sec_equal_zero, buzzer, end_alarm, tick_1hz} !== 12'd0) begin
            n_failed++; $display("[TB] FAIL stop_run: actual rem=%0d flag=%0d buz=%0d end=%0d required 0", remaining, flag_sec_equal_zero, buzzer, end_alarm);
        end
        stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            n_compared++;
            if ({remaining, tick_1hz, flag_sec_equal_zero} !== 10'd0) begin
                n_failed++; $display("[TB] FAIL idle_ignores_start: actual rem=%0d tick=%0d flag=%0d required 0", remaining, tick_1hz, flag_sec_equal_zero);
            end
        end
        start_count = 1'b0; start_alarm = 1'b1;
        cyc(4);
        n_compared++;
        if (buzzer !== 1'b1) begin
            n_failed++; $display("[TB] FAIL alarm_before_stop: actual buz=%0d required 1", buzzer);
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        n_compared++;
        if ({buzzer, end_alarm, remaining} !== 10'd0) begin
            n_failed++; $display("[TB] FAIL stop_alarm: actual buz=%0d end=%0d rem=%0d required 0", buzzer, end_alarm, remaining);
        end
        for (int k = 0; k < 15; k++) begin
            cyc(1);
            n_compared++;
            if ({buzzer, end_alarm, tick_1hz} !== 3'b000) begin
                n_failed++; $display("[TB] FAIL after_stop_alarm: actual buz/end/tick=%0b required 000", {buzzer, end_alarm, tick_1hz});
            end
        end
        start_alarm = 1'b0;
        cyc(1);
    endtask

    task automatic test_zero_load;
        load = 1'b1; mode_count = 8'd0;
        cyc(1);
        n_compared++;
        if ({remaining, flag_sec_equal_zero} !== 9'd0) begin
            n_failed++; $display("[TB] FAIL load0: actual rem=%0d flag=%0d required 0/0", remaining, flag_sec_equal_zero);
        end
        load = 1'b0; start_count = 1'b1;
        cyc(1);
        n_compared++;
        if ({remaining, flag_sec_equal_zero} !== {8'd0, 1'b1}) begin
            n_failed++; $display("[TB] FAIL zero_flag: actual rem=%0d flag=%0d required 0/1", remaining, flag_sec_equal_zero);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            n_compared++;
            if ({remaining, tick_1hz, flag_sec_equal_zero} !== {8'd0, 1'b0, 1'b1}) begin
                n_failed++; $display("[TB] FAIL zero_nowrap: actual rem=%0d tick=%0d flag=%0d required 0/0/1", remaining, tick_1hz, flag_sec_equal_zero);
            end
        end
        stop = 1'b1; cyc(1); stop = 1'b0; start_count = 1'b0;
        cyc(1);
    endtask

    task automatic test_async_reset;
        start_alarm = 1'b1;
        cyc(3);
        n_compared++;
        if (buzzer !== 1'b1) begin
            n_failed++; $display("[TB] FAIL alarm_before_reset: actual buz=%0d required 1", buzzer);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_compared++;
        if (all_out !== 27'd0) begin
            n_failed++; $display("[TB] FAIL async_reset: actual=%0h required=0", all_out);
        end
        cyc(1);
        reset_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cyc(1);
            n_compared++;
            if ({buzzer, end_alarm, tick_1hz} !== 3'b000) begin
                n_failed++; $display("[TB] FAIL held_after_reset: actual buz/end/tick=%0b required 000", {buzzer, end_alarm, tick_1hz});
            end
        end
        start_alarm = 1'b0;
        cyc(1);
        start_alarm = 1'b1;
        cyc(1);
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            n_compared++;
            if ({buzzer, end_alarm} !== {((c / 2) % 2 == 1) && c < 12, c == 12}) begin
                n_failed++; $display("[TB] FAIL rearm_cycle%0d: actual buz/end=%0b required=%0b", c,
                                     {buzzer, end_alarm}, {((c / 2) % 2 == 1) && c < 12, c == 12});
            end
        end
        start_alarm = 1'b0;
        cyc(1);
    endtask

    // Runs every scenario in order, then reports the totals.
    initial begin
        test_reset();
        test_count3();
        test_alarm();
        test_pause120();
        test_stop();
        test_zero_load();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
